uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Parametrised successor to the fixed `$ … *` UART receive tokenizer. It pops bytes from the UART RX FIFO and hunts for a configurable STX byte. Between STX and ETX it streams characters with separator flags and a field index. It can also verify an NMEA-style XOR checksum, and it aborts a frame on overflow, timeout, bad checksum or an unexpected STX, reporting a per-frame error code. It sits between the RX FIFO read port and the command decoder.

## Interface
- STX, default 8'h24, frame start byte ('$').
- ETX, default 8'h2A, frame end byte ('*').
- SEP, default 8'h2C, field separator (',').
- MAX_LEN, default 64, maximum body characters per frame (1..255).
- CHK_EN, default 0, when 1 two uppercase hex ASCII checksum digits follow ETX.
- TIMEOUT_CYC, default 0, in-frame idle timeout in clocks; 0 disables it.
- FIELD_W, default 4, width of field_idx.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- UART_Empty  in  1  FIFO empty flag.
- UART_Dout  in  8  FIFO data, valid the cycle after UART_RD_EN.
- UART_RD_EN  out  1  one-cycle pop pulse.
- frame_start  out  1  pulse, STX accepted.
- frame_end  out  1  pulse, frame completed without error.
- frame_err  out  1  pulse, frame aborted.
- err_code  out  3  1 overflow, 2 timeout, 3 bad checksum, 4 bad hex digit, 5 STX inside frame. Held until the next frame_start.
- frame_len  out  8  body characters emitted (separators included); valid with frame_end/frame_err, held afterwards.
- ch_valid  out  1  pulse, body character on ch_data.
- ch_data  out  8  character; holds its last value.
- ch_is_sep  out  1  qualifies ch_valid, character == SEP.
- field_idx  out  FIELD_W  field index of the emitted character.

## Operation
- Pop rule: UART_RD_EN(N) = !UART_Empty(N-1) && !UART_RD_EN(N-1). At most one byte per 2 clocks; the FIFO never underflows.
- A byte is processed in the cycle after its pop (the "use" cycle).
- States:
  - HUNT: discard non-STX bytes. On STX go to BODY and pulse frame_start. Clear len, field_idx, checksum accumulator and timer.
  - BODY, on each byte in priority order:
    - STX: frame_err with code 5, then frame_start, restarting the frame in the same cycle.
    - ETX: if CHK_EN, go to CHK_HI. Otherwise pulse frame_end and go to HUNT.
    - CR (0x0D) or LF (0x0A): ignored; not counted, not checksummed.
    - len == MAX_LEN: frame_err with code 1, go to HUNT.
    - Otherwise: emit on ch_valid, XOR into the accumulator, len++.
  - After emitting a SEP, field_idx increments and saturates at all-ones. The SEP itself carries the pre-increment index.
  - CHK_HI / CHK_LO: accept only '0'-'9' and 'A'-'F'.
    - Any other byte, including STX, gives frame_err code 4 and a return to HUNT; STX is not re-hunted.
    - After CHK_LO, a matching value pulses frame_end; a mismatch gives frame_err code 3. Either way, go to HUNT.
- Timeout: a counter runs in BODY/CHK_* and clears on every use cycle. If it reaches TIMEOUT_CYC, frame_err code 2 and go to HUNT.
- frame_end and frame_err are never asserted together, except for the code-5 case, which asserts frame_err and frame_start together.

## Timing
- All outputs are registered. For a byte popped in cycle N, it is sampled in N+1 and its effects are visible in N+2.
- Every pulse output is exactly 1 cycle wide.
- Reset values are all 0: UART_RD_EN, frame_start, frame_end, frame_err, ch_valid, ch_is_sep, ch_data, field_idx, frame_len and err_code. The state returns to HUNT.
- Reset asserted mid-frame discards the partial frame with no error pulse. A pop pending at reset is lost, and its FIFO byte is dropped.
- frame_len and field_idx update in the same cycle as the corresponding pulse.

## Test plan
- "$AB,C*" back-to-back in the FIFO, CHK_EN=0:
  - frame_start; then ch_valid ×4 with field_idx 0,0,0,1; ch_is_sep only on ','.
  - frame_end with frame_len=4; UART_RD_EN never on 2 consecutive cycles.
- "xx$A\r\nB*" → leading bytes discarded; 2 characters emitted; frame_len=2.
- CHK_EN=1, "$GP*" + the correct XOR ("17") → frame_end. Repeating with "18" → frame_err code 3. Repeating with "1g" → code 4.
- MAX_LEN=3, "$ABCD*" → 3 characters emitted, then frame_err code 1. The following '*' is discarded in HUNT.
- TIMEOUT_CYC=20: "$A" followed by an empty FIFO → frame_err code 2 exactly 20 clocks after the 'A' use cycle. "$A$B*" → code 5 + frame_start, then 'B' emitted, then frame_end with frame_len=1.
- rst_n pulled low mid-body → all outputs 0 asynchronously. After release, a new "$Z*" parses normally.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops bytes from a UART RX FIFO, hunts for STX, streams
// the frame body (with separator flag and field index) up to ETX, optionally
// verifies a two-digit hex XOR checksum, and aborts a frame on overflow,
// idle timeout, bad checksum, bad hex digit or an unexpected STX.
//
// Handshake: the FIFO read port is a pop/response pair. UART_RD_EN is a
// one-cycle pop request, raised only when UART_Empty was low in the previous
// cycle and no pop was issued then; UART_Dout carries the popped byte in the
// following cycle (the "use" cycle), where it is consumed unconditionally.
// Every output below is a register; pulses last exactly one clock.
module uart_frame_parser #(
  parameter logic [7:0] STX         = 8'h24,
  parameter logic [7:0] ETX         = 8'h2A,
  parameter logic [7:0] SEP         = 8'h2C,
  parameter int         MAX_LEN     = 64,
  parameter bit         CHK_EN      = 1'b0,
  parameter int         TIMEOUT_CYC = 0,
  parameter int         FIELD_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               UART_Empty,
  input  logic [7:0]         UART_Dout,
  output logic               UART_RD_EN,
  output logic               frame_start,
  output logic               frame_end,
  output logic               frame_err,
  output logic [2:0]         err_code,
  output logic [7:0]         frame_len,
  output logic               ch_valid,
  output logic [7:0]         ch_data,
  output logic               ch_is_sep,
  output logic [FIELD_W-1:0] field_idx
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    BODY   = 2'd1,
    CHK_HI = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  localparam logic [2:0] E_OVERFLOW = 3'd1;
  localparam logic [2:0] E_TIMEOUT  = 3'd2;
  localparam logic [2:0] E_BAD_CHK  = 3'd3;
  localparam logic [2:0] E_BAD_HEX  = 3'd4;
  localparam logic [2:0] E_STX      = 3'd5;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Timer holds the number of clocks since the last use cycle (1 right after
  // it), so the error becomes visible TIMEOUT_CYC clocks after that use cycle.
  localparam int             TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0]  TO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [7:0]     MAX_L   = 8'(MAX_LEN);
  localparam logic [FIELD_W-1:0] FLD_MAX = '1;

  state_t             state;
  logic               use_q;
  logic [7:0]         len_q;
  logic [FIELD_W-1:0] fld_q;
  logic [7:0]         acc_q;
  logic [3:0]         hi_q;
  logic [TW-1:0]      timer_q;
  logic [4:0]         hv;

  // {valid, nibble} for an uppercase hex ASCII digit.
  function automatic logic [4:0] hex_val(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, 4'(b - 8'h30)};
    if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
    return 5'd0;
  endfunction

  assign hv = hex_val(UART_Dout);

  // Pop at most every other clock while the FIFO reports data; the byte is used one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      UART_RD_EN <= 1'b0;
      use_q      <= 1'b0;
    end else begin
      UART_RD_EN <= !UART_Empty && !UART_RD_EN;
      use_q      <= UART_RD_EN;
    end
  end

  // Frame FSM: consumes one byte per use cycle and runs the idle timer otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      len_q       <= '0;
      fld_q       <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      timer_q     <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      frame_len   <= '0;
      ch_valid    <= 1'b0;
      ch_data     <= '0;
      ch_is_sep   <= 1'b0;
      field_idx   <= '0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      ch_valid    <= 1'b0;
      ch_is_sep   <= 1'b0;
      if (use_q) begin
        timer_q <= TW'(1);
        case (state)
          HUNT: begin
            if (UART_Dout == STX) begin
              frame_start <= 1'b1;
              err_code    <= '0;
              field_idx   <= '0;
              len_q       <= '0;
              fld_q       <= '0;
              acc_q       <= '0;
              state       <= BODY;
            end
          end
          BODY: begin
            if (UART_Dout == STX) begin
              // Abort the current frame and open a new one on the same byte.
              frame_err   <= 1'b1;
              err_code    <= E_STX;
              frame_len   <= len_q;
              frame_start <= 1'b1;
              field_idx   <= '0;
              len_q       <= '0;
              fld_q       <= '0;
              acc_q       <= '0;
            end else if (UART_Dout == ETX) begin
              if (CHK_EN) begin
                state <= CHK_HI;
              end else begin
                frame_end <= 1'b1;
                frame_len <= len_q;
                state     <= HUNT;
              end
            end else if (UART_Dout == CR || UART_Dout == LF) begin
              // Line endings inside a body are transparent.
            end else if (len_q == MAX_L) begin
              frame_err <= 1'b1;
              err_code  <= E_OVERFLOW;
              frame_len <= len_q;
              state     <= HUNT;
            end else begin
              ch_valid  <= 1'b1;
              ch_data   <= UART_Dout;
              ch_is_sep <= (UART_Dout == SEP);
              field_idx <= fld_q;
              acc_q     <= acc_q ^ UART_Dout;
              len_q     <= len_q + 8'd1;
              if (UART_Dout == SEP && fld_q != FLD_MAX) fld_q <= fld_q + FIELD_W'(1);
            end
          end
          CHK_HI: begin
            if (hv[4]) begin
              hi_q  <= hv[3:0];
              state <= CHK_LO;
            end else begin
              frame_err <= 1'b1;
              err_code  <= E_BAD_HEX;
              frame_len <= len_q;
              state     <= HUNT;
            end
          end
          default: begin
            // CHK_LO: second digit decides the frame outcome.
            frame_len <= len_q;
            state     <= HUNT;
            if (!hv[4]) begin
              frame_err <= 1'b1;
              err_code  <= E_BAD_HEX;
            end else if ({hi_q, hv[3:0]} == acc_q) begin
              frame_end <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= E_BAD_CHK;
            end
          end
        endcase
      end else if (state != HUNT && TIMEOUT_CYC != 0) begin
        if (timer_q >= TO_LAST) begin
          frame_err <= 1'b1;
          err_code  <= E_TIMEOUT;
          frame_len <= len_q;
          state     <= HUNT;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser. Three instances share one FIFO model: their
// pop behaviour is identical, so each sees the same byte stream.
//   0: TIMEOUT_CYC=20, defaults otherwise
//   1: CHK_EN=1
//   2: MAX_LEN=3
// A negedge monitor logs the events of the selected instance; each test task
// compares that log with a hand-written expected list.
module tb_uart_frame_parser;
  localparam int NDUT = 3;

  localparam logic [2:0] K_START = 3'd1;
  localparam logic [2:0] K_CH    = 3'd2;
  localparam logic [2:0] K_END   = 3'd3;
  localparam logic [2:0] K_ERR   = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
    logic       sep;
    logic [3:0] idx;
    logic [2:0] code;
    logic [7:0] len;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       uart_empty = 1'b1;
  logic [7:0] uart_dout  = 8'h00;

  logic       rd_en   [NDUT];
  logic       f_start [NDUT];
  logic       f_end   [NDUT];
  logic       f_err   [NDUT];
  logic [2:0] e_code  [NDUT];
  logic [7:0] f_len   [NDUT];
  logic       ch_v    [NDUT];
  logic [7:0] ch_d    [NDUT];
  logic       ch_s    [NDUT];
  logic [3:0] f_idx   [NDUT];

  uart_frame_parser #(.TIMEOUT_CYC(20)) u_base (
    .clk(clk), .rst_n(rst_n), .UART_Empty(uart_empty), .UART_Dout(uart_dout),
    .UART_RD_EN(rd_en[0]), .frame_start(f_start[0]), .frame_end(f_end[0]),
    .frame_err(f_err[0]), .err_code(e_code[0]), .frame_len(f_len[0]),
    .ch_valid(ch_v[0]), .ch_data(ch_d[0]), .ch_is_sep(ch_s[0]), .field_idx(f_idx[0])
  );

  uart_frame_parser #(.CHK_EN(1'b1)) u_chk (
    .clk(clk), .rst_n(rst_n), .UART_Empty(uart_empty), .UART_Dout(uart_dout),
    .UART_RD_EN(rd_en[1]), .frame_start(f_start[1]), .frame_end(f_end[1]),
    .frame_err(f_err[1]), .err_code(e_code[1]), .frame_len(f_len[1]),
    .ch_valid(ch_v[1]), .ch_data(ch_d[1]), .ch_is_sep(ch_s[1]), .field_idx(f_idx[1])
  );

  uart_frame_parser #(.MAX_LEN(3)) u_max (
    .clk(clk), .rst_n(rst_n), .UART_Empty(uart_empty), .UART_Dout(uart_dout),
    .UART_RD_EN(rd_en[2]), .frame_start(f_start[2]), .frame_end(f_end[2]),
    .frame_err(f_err[2]), .err_code(e_code[2]), .frame_len(f_len[2]),
    .ch_valid(ch_v[2]), .ch_data(ch_d[2]), .ch_is_sep(ch_s[2]), .field_idx(f_idx[2])
  );

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_q[$];

  always @(posedge clk) begin
    if (rd_en[0] && fifo_q.size() > 0) uart_dout <= fifo_q.pop_front();
    uart_empty <= (fifo_q.size() == 0);
  end

  // ---------------- monitor / scoreboard log ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;
  int   cyc      = 0;
  int   b2b_cnt  = 0;
  int   both_cnt = 0;
  logic prev_rd [NDUT];
  ev_t  ev_q[$];
  int   ev_cyc[$];

  function automatic ev_t mk_ev(input logic [2:0] k, input logic [7:0] d, input logic s,
                                input logic [3:0] ix, input logic [2:0] c, input logic [7:0] l);
    ev_t e;
    e.kind = k; e.data = d; e.sep = s; e.idx = ix; e.code = c; e.len = l;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      if (rd_en[i] === 1'b1 && prev_rd[i] === 1'b1) b2b_cnt++;
      if (f_end[i] === 1'b1 && f_err[i] === 1'b1) both_cnt++;
      prev_rd[i] = rd_en[i];
    end
    if (rst_n) begin
      if (f_err[sel]) begin
        ev_q.push_back(mk_ev(K_ERR, 8'h00, 1'b0, 4'h0, e_code[sel], f_len[sel]));
        ev_cyc.push_back(cyc);
      end
      if (f_start[sel]) begin
        ev_q.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'h0, 3'd0, 8'h00));
        ev_cyc.push_back(cyc);
      end
      if (ch_v[sel]) begin
        ev_q.push_back(mk_ev(K_CH, ch_d[sel], ch_s[sel], f_idx[sel], 3'd0, 8'h00));
        ev_cyc.push_back(cyc);
      end
      if (f_end[sel]) begin
        ev_q.push_back(mk_ev(K_END, 8'h00, 1'b0, 4'h0, 3'd0, f_len[sel]));
        ev_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    run(3);
    rst_n = 1'b1;
    run(3);
    ev_q.delete();
    ev_cyc.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NDUT; i++) begin
      n_checks++;
      if ({rd_en[i], f_start[i], f_end[i], f_err[i], e_code[i], f_len[i],
           ch_v[i], ch_d[i], ch_s[i], f_idx[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d got rd%b st%b en%b er%b code%0d len%0d v%b d%h s%b idx%0d want all 0",
                 i, rd_en[i], f_start[i], f_end[i], f_err[i], e_code[i], f_len[i],
                 ch_v[i], ch_d[i], ch_s[i], f_idx[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t exp[$];
    sel = 0;
    do_reset();
    push_str("$AB,C*$X,*");
    run(40);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h41, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h42, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h2C, 1'b1, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h43, 1'b0, 4'd1, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END,   8'h00, 1'b0, 4'd0, 3'd0, 8'd4));
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h58, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h2C, 1'b1, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END,   8'h00, 1'b0, 4'd0, 3'd0, 8'd2));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL back_to_back event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL back_to_back ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL back_to_back ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
    n_checks++;
    if (e_code[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL back_to_back err_code got %0d want 0", e_code[0]);
    end
  endtask

  task automatic test_hunt_crlf();
    ev_t exp[$];
    sel = 0;
    do_reset();
    push_str("xx$A");
    fifo_q.push_back(8'h0D);
    fifo_q.push_back(8'h0A);
    push_str("B*");
    run(35);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h41, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h42, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END,   8'h00, 1'b0, 4'd0, 3'd0, 8'd2));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL hunt_crlf event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL hunt_crlf ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL hunt_crlf ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_checksum();
    ev_t exp[$];
    sel = 1;
    do_reset();
    // 'G' ^ 'P' = 0x47 ^ 0x50 = 0x17
    push_str("$GP*17");
    run(25);
    push_str("$GP*18");
    run(25);
    push_str("$GP*1g");
    run(25);
    for (int f = 0; f < 3; f++) begin
      exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
      exp.push_back(mk_ev(K_CH,    8'h47, 1'b0, 4'd0, 3'd0, 8'd0));
      exp.push_back(mk_ev(K_CH,    8'h50, 1'b0, 4'd0, 3'd0, 8'd0));
    end
    exp.insert(3, mk_ev(K_END, 8'h00, 1'b0, 4'd0, 3'd0, 8'd2));
    exp.insert(7, mk_ev(K_ERR, 8'h00, 1'b0, 4'd0, 3'd3, 8'd2));
    exp.push_back(mk_ev(K_ERR, 8'h00, 1'b0, 4'd0, 3'd4, 8'd2));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL checksum event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL checksum ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL checksum ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
    n_checks++;
    if (e_code[1] !== 3'd4 || f_len[1] !== 8'd2) begin
      n_fail++;
      $display("FAIL checksum held_code_len got code%0d len%0d want code4 len2", e_code[1], f_len[1]);
    end
  endtask

  task automatic test_overflow();
    ev_t exp[$];
    sel = 2;
    do_reset();
    push_str("$ABCD*$Q*");
    run(35);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h41, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h42, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h43, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_ERR,   8'h00, 1'b0, 4'd0, 3'd1, 8'd3));
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h51, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END,   8'h00, 1'b0, 4'd0, 3'd0, 8'd1));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL overflow event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL overflow ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL overflow ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    ev_t exp[$];
    sel = 0;
    do_reset();
    push_str("$A");
    run(45);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h41, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_ERR,   8'h00, 1'b0, 4'd0, 3'd2, 8'd1));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL timeout event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL timeout ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL timeout ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
    // ch_valid is seen 1 clock after the 'A' use cycle, the error 20 clocks after it.
    n_checks++;
    if (ev_cyc.size() < 3) begin
      n_fail++;
      $display("FAIL timeout latency got %0d events want 3", ev_cyc.size());
    end else if (ev_cyc[2] - ev_cyc[1] != 19) begin
      n_fail++;
      $display("FAIL timeout latency got %0d want 19 clocks after ch_valid", ev_cyc[2] - ev_cyc[1]);
    end
  endtask

  task automatic test_stx_in_body();
    ev_t exp[$];
    sel = 0;
    do_reset();
    push_str("$A$B*");
    run(30);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h41, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_ERR,   8'h00, 1'b0, 4'd0, 3'd5, 8'd1));
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h42, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END,   8'h00, 1'b0, 4'd0, 3'd0, 8'd1));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL stx_in_body event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL stx_in_body ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL stx_in_body ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
    n_checks++;
    if (ev_cyc.size() < 4) begin
      n_fail++;
      $display("FAIL stx_in_body same_cycle got %0d events want 6", ev_cyc.size());
    end else if (ev_cyc[2] != ev_cyc[3]) begin
      n_fail++;
      $display("FAIL stx_in_body same_cycle got err@%0d start@%0d want equal", ev_cyc[2], ev_cyc[3]);
    end
  endtask

  task automatic test_field_saturate();
    ev_t exp[$];
    sel = 0;
    do_reset();
    push_str("$,,,,,,,,,,,,,,,,,*");
    run(55);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    for (int i = 0; i < 17; i++)
      exp.push_back(mk_ev(K_CH, 8'h2C, 1'b1, (i < 15) ? 4'(i) : 4'd15, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END, 8'h00, 1'b0, 4'd0, 3'd0, 8'd17));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL field_saturate event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL field_saturate ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL field_saturate ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_t exp[$];
    int  n_err;
    sel = 0;
    do_reset();
    push_str("$ABCDEFGH");
    run(12);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_en[0], f_start[0], f_end[0], f_err[0], e_code[0], f_len[0],
         ch_v[0], ch_d[0], ch_s[0], f_idx[0]} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got rd%b st%b en%b er%b code%0d len%0d v%b d%h s%b idx%0d want all 0",
               rd_en[0], f_start[0], f_end[0], f_err[0], e_code[0], f_len[0],
               ch_v[0], ch_d[0], ch_s[0], f_idx[0]);
    end
    n_err = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == K_ERR) n_err++;
    n_checks++;
    if (n_err != 0 || ev_q.size() < 3) begin
      n_fail++;
      $display("FAIL reset_partial got %0d events %0d errors want >=3 events 0 errors", ev_q.size(), n_err);
    end
    fifo_q.delete();
    run(4);
    rst_n = 1'b1;
    run(3);
    ev_q.delete();
    ev_cyc.delete();
    push_str("$Z*");
    run(20);
    exp.push_back(mk_ev(K_START, 8'h00, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_CH,    8'h5A, 1'b0, 4'd0, 3'd0, 8'd0));
    exp.push_back(mk_ev(K_END,   8'h00, 1'b0, 4'd0, 3'd0, 8'd1));
    n_checks++;
    if (ev_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL after_reset event_count got %0d want %0d", ev_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= ev_q.size()) begin
        n_fail++;
        $display("FAIL after_reset ev%0d got none want %h", i, exp[i]);
      end else if (ev_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL after_reset ev%0d got %h want %h", i, ev_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (b2b_cnt != 0) begin
      n_fail++;
      $display("FAIL rd_en_spacing got %0d consecutive pops want 0", b2b_cnt);
    end
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL end_err_exclusive got %0d overlaps want 0", both_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NDUT; i++) prev_rd[i] = 1'b0;
    test_reset();
    test_back_to_back();
    test_hunt_crlf();
    test_checksum();
    test_overflow();
    test_timeout();
    test_stx_in_body();
    test_field_saturate();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
